// File: rtl/regfile_wb_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_scoreboard_pkg
// Purpose  : Shared sizes and writeback-source encoding for the register-file
//            writeback controller and its round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_wb_scoreboard_pkg;

  localparam int DW   = 32;       // register data width
  localparam int AW   = 5;        // register address width
  localparam int NREG = 2 ** AW;  // architectural registers

  // Writeback source identity, used as the round-robin pointer.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  // The source that should win a tie given the previous winner.
  function automatic wb_src_e tie_winner(input wb_src_e last);
    return (last == SRC_ALU) ? SRC_LSU : SRC_ALU;
  endfunction

endpackage : regfile_wb_scoreboard_pkg
`default_nettype wire

// File: rtl/regfile_wb_scoreboard_arb.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_arbiter
// Purpose  : Two-way round-robin arbiter for the single register-file write
//            port. Produces a one-hot (or empty) grant combinationally and
//            remembers the last winner so ties alternate.
// Revision : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter
  import regfile_wb_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic alu_req_i,
  input  logic lsu_req_i,
  output logic alu_gnt_o,
  output logic lsu_gnt_o
);

  wb_src_e last_grant_q;
  wb_src_e last_grant_d;
  wb_src_e winner;

  // Grant selection and pointer next-state; nothing is granted while in reset.
  always_comb begin
    alu_gnt_o    = 1'b0;
    lsu_gnt_o    = 1'b0;
    last_grant_d = last_grant_q;
    winner       = tie_winner(last_grant_q);
    if (rst_n) begin
      if (alu_req_i && lsu_req_i) begin
        alu_gnt_o = (winner == SRC_ALU);
        lsu_gnt_o = (winner == SRC_LSU);
      end else begin
        alu_gnt_o = alu_req_i;
        lsu_gnt_o = lsu_req_i;
      end
      if (alu_gnt_o) begin
        last_grant_d = SRC_ALU;
      end else if (lsu_gnt_o) begin
        last_grant_d = SRC_LSU;
      end
    end
  end

  // Pointer register; resets to LSU so the ALU wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= SRC_LSU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule : wb_rr_arbiter
`default_nettype wire

// File: rtl/regfile_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_scoreboard
// Purpose  : Writeback controller in front of the 32x32 register file.
//            Arbitrates ALU/LSU writebacks onto one registered write port
//            and keeps a per-register busy scoreboard that stalls issue on
//            RAW and WAW hazards.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_scoreboard
  import regfile_wb_scoreboard_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_wb_valid,
  input  logic [AW-1:0]   alu_wb_addr,
  input  logic [DW-1:0]   alu_wb_data,
  output logic            alu_wb_ready,
  input  logic            lsu_wb_valid,
  input  logic [AW-1:0]   lsu_wb_addr,
  input  logic [DW-1:0]   lsu_wb_data,
  output logic            lsu_wb_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wa,
  output logic [DW-1:0]   rf_wd,
  input  logic            iss_alloc_valid,
  input  logic [AW-1:0]   iss_alloc_addr,
  input  logic [AW-1:0]   iss_src1_addr,
  input  logic [AW-1:0]   iss_src2_addr,
  output logic            iss_stall,
  output logic [NREG-1:0] busy_vec
);

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic gnt_alu;
  logic gnt_lsu;

  wb_rr_arbiter u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_req_i (alu_wb_valid),
    .lsu_req_i (lsu_wb_valid),
    .alu_gnt_o (gnt_alu),
    .lsu_gnt_o (gnt_lsu)
  );

  assign alu_wb_ready = gnt_alu;
  assign lsu_wb_ready = gnt_lsu;

  logic          gnt_any;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  // Steer the granted request onto the shared writeback path.
  always_comb begin
    gnt_any = gnt_alu | gnt_lsu;
    wb_addr = '0;
    wb_data = '0;
    if (gnt_alu) begin
      wb_addr = alu_wb_addr;
      wb_data = alu_wb_data;
    end else if (gnt_lsu) begin
      wb_addr = lsu_wb_addr;
      wb_data = lsu_wb_data;
    end
  end

  // --------------------------------------------------------------------------
  // Registered write port
  // --------------------------------------------------------------------------
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_wa_q, rf_wa_d;
  logic [DW-1:0] rf_wd_q, rf_wd_d;

  // A granted write to r0 is absorbed: the grant still counts but the
  // register file never sees an enable, and address/data keep their values.
  always_comb begin
    rf_we_d = gnt_any && (wb_addr != '0);
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    if (rf_we_d) begin
      rf_wa_d = wb_addr;
      rf_wd_d = wb_data;
    end
  end

  // Write-port registers give the one-cycle grant-to-write latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;

  // --------------------------------------------------------------------------
  // Busy scoreboard
  // --------------------------------------------------------------------------
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            alloc_ok;

  // Stall on any busy source (RAW) or a busy destination (WAW). busy_q[0]
  // is held at zero, so r0 operands never stall.
  always_comb begin
    iss_stall = busy_q[iss_src1_addr]
              | busy_q[iss_src2_addr]
              | (iss_alloc_valid & busy_q[iss_alloc_addr]);
    alloc_ok  = iss_alloc_valid && !iss_stall && (iss_alloc_addr != '0);
  end

  // Clear on writeback first, then set on alloc, so a same-edge set wins.
  always_comb begin
    busy_d = busy_q;
    if (gnt_any) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (alloc_ok) begin
      busy_d[iss_alloc_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule : regfile_wb_scoreboard
`default_nettype wire
